// File: rtl/alu_arb_pkg.sv
// Shared op codes and FSM state encodings for the two-requester ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_OR  = 3'b010,
    OP_AND = 3'b011
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by both requesters; undefined op codes yield 0.
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter around one shared ALU with a single registered result slot.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero
);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  logic             hs, grant, sel;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [2:0]       alu_op;

  // Owner handshake frees the slot, so a new grant can land in the same cycle.
  assign hs = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

`ifdef ALU_ARB_RR_EN
  logic last_q;
  assign sel = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  always_ff @(posedge clk) begin
    if (reset)      last_q <= 1'b1;
    else if (grant) last_q <= sel;
  end
`else
  assign sel = ~req0_valid;
`endif

  assign alu_a  = sel ? req1_a  : req0_a;
  assign alu_b  = sel ? req1_b  : req0_b;
  assign alu_op = sel ? req1_op : req0_op;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && (state_q == IDLE || hs) && (req0_valid || req1_valid)) begin
      grant      = 1'b1;
      req0_ready = ~sel;
      req1_ready = sel;
      state_d    = RESP;
      owner_d    = sel;
    end else if (hs) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (grant) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
      end
    end
  end

  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) &&  owner_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + randomized bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int W = 32;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
  logic [2:0] req0_op, req1_op;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one held response (or none) plus the last granted requester.
  bit         m_busy, m_owner, m_last, m_zero;
  logic [W-1:0] m_res;
  int         obs_gnt;

  function automatic logic [W-1:0] ref_alu(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a | b;
      3'd3:    return a & b;
      default: return '0;
    endcase
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT to model mid-cycle, advance the model, move past the edge.
  task automatic step();
    bit hs;
    int gnt;
    @(negedge clk);
    hs  = m_busy && (m_owner ? rsp1_ready : rsp0_ready);
    gnt = -1;
    if (!reset && (!m_busy || hs)) begin
      if (req0_valid && req1_valid) gnt = RR ? (m_last ? 0 : 1) : 0;
      else if (req0_valid)          gnt = 0;
      else if (req1_valid)          gnt = 1;
    end
    obs_gnt = req1_ready ? 1 : (req0_ready ? 0 : -1);
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, gnt == 0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, gnt == 1});
    chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, m_busy && !m_owner});
    chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, m_busy && m_owner});
    if (m_busy) begin
      chk("rsp_result", m_owner ? rsp1_result : rsp0_result, m_res);
      chk("rsp_zero", {31'b0, m_owner ? rsp1_zero : rsp0_zero}, {31'b0, m_zero});
    end
    if (reset) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_res = '0; m_zero = 0;
    end else if (gnt >= 0) begin
      m_res   = (gnt == 1) ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
      m_zero  = (m_res == '0);
      m_owner = (gnt == 1);
      m_last  = (gnt == 1);
      m_busy  = 1;
    end else if (hs) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq [4];
    int got_seq [4];
    logic [W-1:0] held;
    bit acc0, acc1;

    m_busy = 0; m_owner = 0; m_last = 1; m_res = '0; m_zero = 0; obs_gnt = -1;
    reset = 1'b1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0; rsp0_ready = 1;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0; rsp1_ready = 1;
    step(); step();
    reset = 1'b0;
    chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("rst_result", rsp0_result, 32'd0);
    chk("rst_zero", {31'b0, rsp0_zero}, 32'd0);

    // Single add on requester 0, one-cycle latency.
    req0_valid = 1; req0_a = 32'h5; req0_b = 32'h3; req0_op = 3'b000;
    step();
    chk("add_grant", obs_gnt, 32'd0);
    req0_valid = 0;
    chk("add_rsp_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("add_result", rsp0_result, 32'h8);
    chk("add_zero", {31'b0, rsp0_zero}, 32'd0);
    step();

    // Wrapping subtract, then an undefined op.
    req1_valid = 1; req1_a = 32'h0; req1_b = 32'h1; req1_op = 3'b001;
    step();
    req1_valid = 0;
    chk("sub_wrap", rsp1_result, 32'hFFFF_FFFF);
    req1_valid = 1; req1_a = 32'h7; req1_b = 32'h9; req1_op = 3'b101;
    step();
    req1_valid = 0;
    chk("op101_result", rsp1_result, 32'h0);
    chk("op101_zero", {31'b0, rsp1_zero}, 32'd1);

    // Contention with sustained acceptance; last grant was requester 1.
    exp_seq = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
    req0_valid = 1; req0_a = 32'h10; req0_b = 32'h1; req0_op = 3'b000;
    req1_valid = 1; req1_a = 32'h10; req1_b = 32'h1; req1_op = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step();
      got_seq[i] = obs_gnt;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("contend_gnt%0d", i), got_seq[i], exp_seq[i]);

    // Backpressure on requester 0's response.
    req1_valid = 0;
    step();
    while (!(m_busy && !m_owner)) step();
    held = rsp0_result;
    req1_valid = 1; rsp0_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_held_result", rsp0_result, held);
      chk("bp_no_grant", obs_gnt, -1);
    end
    rsp0_ready = 1;
    step();
    chk("bp_release_grant", {31'b0, obs_gnt >= 0}, 32'd1);

    // Reset while requester 0 holds a result.
    req1_valid = 0; req0_valid = 1; rsp1_ready = 1;
    step();
    while (!(m_busy && !m_owner)) step();
    req0_valid = 0; rsp0_ready = 0;
    chk("pre_rst_valid", {31'b0, rsp0_valid}, 32'd1);
    reset = 1;
    step();
    reset = 0; rsp0_ready = 1;
    chk("mid_rst_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("mid_rst_result", rsp0_result, 32'd0);
    req0_valid = 1; req1_valid = 1;
    step();
    chk("post_rst_gnt", obs_gnt, 32'd0);

    // Randomized traffic obeying the hold-until-ready rule.
    acc0 = 1; acc1 = 1;
    for (int c = 0; c < 400; c++) begin
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a  = $urandom_range(0, 1) ? $urandom() : $urandom_range(0, 3);
        req0_b  = $urandom_range(0, 1) ? $urandom() : $urandom_range(0, 3);
        req0_op = 3'($urandom_range(0, 7));
      end
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a  = $urandom_range(0, 1) ? $urandom() : $urandom_range(0, 3);
        req1_b  = $urandom_range(0, 1) ? $urandom() : $urandom_range(0, 3);
        req1_op = 3'($urandom_range(0, 7));
      end
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 63) == 0);
      step();
      acc0 = (obs_gnt == 0);
      acc1 = (obs_gnt == 1);
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
